clock_seg_display: RTL and testbench

Display stage downstream of the seconds/minutes counter of the digital clock. Consumes the binary `seconds` (6-bit) and `minutes` (4-bit) values, converts them to BCD with a sequential double-dabble engine, and drives a 4-digit, common-anode, time-multiplexed seven-segment display as MM.SS. Runs entirely on the 100 MHz `hclk` domain.

---
 rtl/clock_disp_pkg.sv | 42 ++++
 rtl/bin2bcd6_seq.sv | 43 ++++
 rtl/clock_seg_display.sv | 116 +++++++++++
 tb/tb_clock_seg_display.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the MM.SS seven-segment display stage.
package clock_disp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV_SEC = 2'd1,
    CONV_MIN = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam int NUM_DIGITS = 4;

  // Active-low, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd6_seq.sv
// Serial double-dabble: 6-bit binary to two BCD nibbles, one shift per clock.
// The start edge already performs the first shift; done flags the cycle whose edge does the sixth.
module bin2bcd6_seq
  import clock_disp_pkg::*;
(
  input  logic       hclk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] bcd
);

  logic [13:0] sh;   // {tens, ones, remaining binary}
  logic [2:0]  cnt;

  function automatic logic [13:0] dabble(input logic [13:0] x);
    logic [13:0] y;
    y = x;
    if (y[13:10] >= 4'd5) y[13:10] = y[13:10] + 4'd3;
    if (y[9:6]   >= 4'd5) y[9:6]   = y[9:6]   + 4'd3;
    return {y[12:0], 1'b0};
  endfunction

  always_ff @(posedge hclk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= dabble({8'd0, din});
      cnt <= 3'd1;
    end else if (cnt != 3'd0) begin
      sh  <= dabble(sh);
      cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
    end
  end

  assign busy = (cnt != 3'd0);
  assign done = (cnt == 3'd5);
  assign bcd  = sh[13:6];

endmodule

// File: rtl/clock_seg_display.sv
// MM.SS display: snapshots the time, converts it to BCD on a shared serial engine,
// commits all four digits at once and scans them onto a common-anode display.
module clock_seg_display
  import clock_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LEAD_BLANK  = 1'b1
) (
  input  logic       hclk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [3:0] minutes,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t                         state;
  logic [9:0]                     last_conv;
  logic [5:0]                     snap_sec;
  logic [3:0]                     snap_min;
  logic [7:0]                     sec_bcd;
  logic [NUM_DIGITS-1:0][3:0]     digit;

  logic       eng_start, eng_busy, eng_done;
  logic [5:0] eng_din;
  logic [7:0] eng_bcd;

  // The engine is kicked whenever a conversion state finds it idle
  assign eng_start = ((state == CONV_SEC) || (state == CONV_MIN)) && !eng_busy;
  assign eng_din   = (state == CONV_MIN) ? {2'b00, snap_min} : snap_sec;

  bin2bcd6_seq u_bcd (
    .hclk  (hclk),
    .reset (reset),
    .start (eng_start),
    .din   (eng_din),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_ff @(posedge hclk) begin
    if (reset) begin
      state     <= IDLE;
      last_conv <= '0;
      snap_sec  <= '0;
      snap_min  <= '0;
      sec_bcd   <= '0;
      digit     <= '0;
    end else begin
      case (state)
        IDLE: if ({minutes, seconds} != last_conv) begin
          snap_sec  <= seconds;
          snap_min  <= minutes;
          last_conv <= {minutes, seconds};
          state     <= CONV_SEC;
        end
        CONV_SEC: if (eng_done) state <= CONV_MIN;
        CONV_MIN: begin
          // seconds result is still held by the engine until the minutes pass loads it
          if (eng_start) sec_bcd <= eng_bcd;
          if (eng_done)  state   <= COMMIT;
        end
        COMMIT: begin
          digit <= {eng_bcd, sec_bcd};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  logic [CW-1:0] rcnt;
  logic [1:0]    idx;

  always_ff @(posedge hclk) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  logic [3:0] cur;
  logic [6:0] seg_nxt;

  assign cur = digit[idx];

  always_comb begin
    seg_nxt = bcd_to_seg(cur);
    if (LEAD_BLANK && (idx == 2'd3) && (cur == 4'd0)) seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      an  <= 4'b1110;
      seg <= SEG_0;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_nxt;
      dp  <= (idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_clock_seg_display.sv
// Randomized self-checking bench for clock_seg_display; digits are predicted with /10 and %10.
module tb_clock_seg_display;

  logic       hclk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] seconds = '0;
  logic [3:0] minutes = '0;
  logic [3:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb, busy, busy_nb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur_mm = 0;
  int cur_ss = 0;

  localparam logic [6:0] PAT [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  clock_seg_display #(.REFRESH_DIV(4), .LEAD_BLANK(1'b1)) dut (
    .hclk(hclk), .reset(reset), .seconds(seconds), .minutes(minutes),
    .an(an), .seg(seg), .dp(dp), .busy(busy));

  clock_seg_display #(.REFRESH_DIV(4), .LEAD_BLANK(1'b0)) dut_nb (
    .hclk(hclk), .reset(reset), .seconds(seconds), .minutes(minutes),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb), .busy(busy_nb));

  function automatic logic [6:0] model_seg(int mm, int ss, int pos, bit lead_blank);
    int d;
    case (pos)
      0:       d = ss % 10;
      1:       d = ss / 10;
      2:       d = mm % 10;
      default: d = mm / 10;
    endcase
    if (pos == 3 && lead_blank && d == 0) return 7'b1111111;
    return PAT[d];
  endfunction

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  // Samples one full scan period; records the pattern seen for each digit slot
  task automatic scan(output logic [3:0][6:0] sa, output logic [3:0][6:0] sb,
                      output logic [3:0] dpm, output int bad);
    int idx, prev, run, runs;
    bad = 0; prev = -1; run = 0; runs = 0;
    sa = 'x; sb = 'x; dpm = 'x;
    for (int n = 0; n < 20; n++) begin
      tick();
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0 || an_nb !== an || dp_nb !== dp) bad++;
      else begin
        sa[idx] = seg; sb[idx] = seg_nb; dpm[idx] = dp;
        if (idx == prev) run++;
        else begin
          if (prev >= 0) begin
            if (idx != (prev + 1) % 4) bad++;
            if (runs > 0 && run != 4) bad++;
            runs++;
          end
          run = 1; prev = idx;
        end
      end
    end
  endtask

  // Waits for a conversion to start and finish; len = cycles busy was seen high
  task automatic run_conv(output int len, output bit to);
    int n;
    to = 1'b0; len = 0; n = 0;
    do begin tick(); n++; end while (busy !== 1'b1 && n < 40);
    if (busy !== 1'b1) to = 1'b1;
    else while (busy === 1'b1 && len < 40) begin len++; tick(); end
  endtask

  task automatic test_reset;
    reset = 1'b1; seconds = '0; minutes = '0;
    tick(); tick();
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b want 1110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b want 1000000", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    cur_mm = 0; cur_ss = 0;
  endtask

  task automatic test_idle_zero;
    int hi;
    logic [3:0][6:0] sa, sb;
    logic [3:0] dpm;
    int bad;
    hi = 0;
    for (int n = 0; n < 20; n++) begin tick(); if (busy !== 1'b0) hi++; end
    checks++; if (hi != 0) begin errors++; $display("FAIL idle_busy: got %0d busy cycles want 0", hi); end
    scan(sa, sb, dpm, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_an_seq: got %0d bad samples want 0", bad); end
    checks++; if (dpm !== 4'b1011) begin errors++; $display("FAIL idle_dp: got %b want 1011", dpm); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (sa[p] !== model_seg(0, 0, p, 1'b1)) begin
        errors++; $display("FAIL idle_seg%0d: got %b want %b", p, sa[p], model_seg(0, 0, p, 1'b1));
      end
    end
    checks++;
    if (sb[3] !== model_seg(0, 0, 3, 1'b0)) begin
      errors++; $display("FAIL idle_noblank_seg3: got %b want %b", sb[3], model_seg(0, 0, 3, 1'b0));
    end
  endtask

  task automatic test_change_during_conv;
    logic [3:0] prev_an;
    logic [6:0] first0;
    bit got, seen_busy;
    int n, t1, t2;
    logic [3:0][6:0] sa, sb;
    logic [3:0] dpm;
    int bad;
    // align to the start of a digit0 slot so its pattern is visible between the two commits
    prev_an = an; n = 0;
    do begin prev_an = an; tick(); n++; end while (!(an === 4'b1110 && prev_an !== 4'b1110) && n < 40);
    checks++; if (n >= 40) begin errors++; $display("FAIL chg_align: got timeout want digit0 slot"); end
    seconds = 6'd10; minutes = 4'd3;
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b1 && n < 10);
    repeat (7) tick();
    seconds = 6'd11;
    n = 0;
    while (busy === 1'b1 && n < 40) begin tick(); n++; end
    t1 = cyc;
    got = 1'b0; seen_busy = 1'b0; t2 = -1; first0 = 'x;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (an === 4'b1110 && !got && (cyc - t1) <= 14) begin first0 = seg; got = 1'b1; end
      if (busy === 1'b1) seen_busy = 1'b1;
      else if (seen_busy) begin t2 = cyc; break; end
    end
    checks++; if (first0 !== PAT[0]) begin errors++; $display("FAIL chg_first_commit_seg0: got %b want %b", first0, PAT[0]); end
    checks++; if (t2 - t1 != 14) begin errors++; $display("FAIL chg_commit_gap: got %0d want 14", t2 - t1); end
    scan(sa, sb, dpm, bad);
    cur_mm = 3; cur_ss = 11;
    checks++; if (bad != 0) begin errors++; $display("FAIL chg_an_seq: got %0d bad samples want 0", bad); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (sa[p] !== model_seg(3, 11, p, 1'b1)) begin
        errors++; $display("FAIL chg_seg%0d: got %b want %b", p, sa[p], model_seg(3, 11, p, 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid_conv;
    int n, len;
    bit to;
    logic [3:0][6:0] sa, sb;
    logic [3:0] dpm;
    int bad;
    seconds = 6'd59; minutes = 4'd12;
    n = 0;
    do begin tick(); n++; end while (busy !== 1'b1 && n < 10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_start: got busy %b want 1", busy); end
    repeat (4) tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rstmid_an: got %b want 1110", an); end
    checks++; if (seg !== PAT[0]) begin errors++; $display("FAIL rstmid_seg: got %b want %b", seg, PAT[0]); end
    tick();
    reset = 1'b0;
    run_conv(len, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_restart: got timeout want conversion"); end
    checks++; if (len != 13) begin errors++; $display("FAIL rstmid_busy_len: got %0d want 13", len); end
    scan(sa, sb, dpm, bad);
    cur_mm = 12; cur_ss = 59;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (sa[p] !== model_seg(12, 59, p, 1'b1)) begin
        errors++; $display("FAIL rstmid_seg%0d: got %b want %b", p, sa[p], model_seg(12, 59, p, 1'b1));
      end
    end
  endtask

  task automatic test_conversions;
    int dir_mm [4] = '{9, 15, 7, 0};
    int dir_ss [4] = '{45, 63, 30, 5};
    int mm, ss, len, bad;
    bit to;
    logic [3:0][6:0] sa, sb;
    logic [3:0] dpm;
    for (int k = 0; k < 20; k++) begin
      if (k < 4) begin mm = dir_mm[k]; ss = dir_ss[k]; end
      else begin
        do begin
          mm = int'($urandom_range(15, 0)); ss = int'($urandom_range(63, 0));
        end while (mm == cur_mm && ss == cur_ss);
      end
      seconds = 6'(ss); minutes = 4'(mm);
      run_conv(len, to);
      scan(sa, sb, dpm, bad);
      cur_mm = mm; cur_ss = ss;
      checks++; if (to) begin errors++; $display("FAIL conv_start %0d:%0d: got timeout want busy", mm, ss); end
      checks++; if (len != 13) begin errors++; $display("FAIL conv_busy_len %0d:%0d: got %0d want 13", mm, ss, len); end
      checks++; if (bad != 0) begin errors++; $display("FAIL conv_an_seq %0d:%0d: got %0d bad want 0", mm, ss, bad); end
      checks++; if (dpm !== 4'b1011) begin errors++; $display("FAIL conv_dp %0d:%0d: got %b want 1011", mm, ss, dpm); end
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (sa[p] !== model_seg(mm, ss, p, 1'b1)) begin
          errors++; $display("FAIL conv_seg%0d %0d:%0d: got %b want %b", p, mm, ss, sa[p], model_seg(mm, ss, p, 1'b1));
        end
        checks++;
        if (sb[p] !== model_seg(mm, ss, p, 1'b0)) begin
          errors++; $display("FAIL conv_noblank_seg%0d %0d:%0d: got %b want %b", p, mm, ss, sb[p], model_seg(mm, ss, p, 1'b0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_zero();
    test_change_during_conv();
    test_reset_mid_conv();
    test_conversions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
